// File: rtl/sparse_pkg.sv
// Shared types and widths for the sparse activation encoder.
// Holds the pair record, the FSM state encoding and a saturating count helper.
package sparse_pkg;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [IDX_W-1:0]  index;
    logic              last;
  } pair_t;

  localparam int PAIR_W = $bits(pair_t);

  // Count sticks at all-ones so a fully dense long vector never wraps to a small value.
  function automatic logic [7:0] sat_inc(input logic [7:0] count);
    return (count == 8'hFF) ? count : count + 8'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO for encoder output pairs; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored; no push-pop bypass.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sparse_encoder.sv
// Dense-to-sparse activation encoder: emits (value, index, last) pairs for nonzero elements.
// Optional NNZ_COUNT_EN adds nnz_count, the nonzero count of the last completed vector.
module sparse_encoder
  import sparse_pkg::*;
#(
  parameter int VEC_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
`ifdef NNZ_COUNT_EN
  ,
  output logic [7:0]        nnz_count
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             at_last;
  logic             is_nonzero;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  pair_t            push_pair;
  pair_t            head_pair;

  assign accept     = din_valid && din_ready;
  assign at_last    = (idx == LAST_IDX);
  assign is_nonzero = (din != '0);
  // The closing element is always forwarded so the PE sees the vector boundary.
  assign push       = accept && (at_last || is_nonzero);
  assign pop        = out_valid && out_ready;
  assign din_ready  = !fifo_full && (state != ST_DRAIN);

  always_comb begin
    push_pair       = '0;
    push_pair.val   = din;
    push_pair.index = idx;
    push_pair.last  = at_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (accept) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = at_last ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (accept && at_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(PAIR_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_pair),
    .dout (head_pair),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Storage is not reset, so the head is masked to keep outputs at zero while empty.
  always_comb begin
    out_valid = !fifo_empty;
    out_val   = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      out_val   = head_pair.val;
      out_index = head_pair.index;
      out_last  = head_pair.last;
    end
  end

`ifdef NNZ_COUNT_EN
  logic [7:0] nnz_run;
  logic [7:0] nnz_pend;

  // The closing element's count is folded in at accept time and published on done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nnz_run   <= '0;
      nnz_pend  <= '0;
      nnz_count <= '0;
    end else begin
      if (accept) begin
        if (at_last) begin
          nnz_pend <= is_nonzero ? sat_inc(nnz_run) : nnz_run;
          nnz_run  <= '0;
        end else if (is_nonzero) begin
          nnz_run <= sat_inc(nnz_run);
        end
      end
      if (done) nnz_count <= nnz_pend;
    end
  end
`endif

endmodule

// File: tb/tb_sparse_encoder.sv
// Randomized scoreboard bench for sparse_encoder with VEC_LEN=8, FIFO_DEPTH=4.
// Checks nnz_count too when NNZ_COUNT_EN is defined.
`timescale 1ns/1ps
module tb_sparse_encoder;

  localparam int VEC_LEN    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 2000;

  typedef struct {
    int val;
    int index;
    bit last;
  } exp_pair_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] out_val;
  logic [7:0] out_index;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       done;
`ifdef NNZ_COUNT_EN
  logic [7:0] nnz_count;
`endif

  int        errors = 0;
  int        checks = 0;
  exp_pair_t sb[$];
  int        nnz_q[$];
  int        vec_pos = 0;
  int        nnz_cur = 0;
  int        accepted = 0;
  int        done_count = 0;
  int        ready_mode = 1;
  bit        draining = 1'b0;
  bit        prev_last_pop = 1'b0;
  bit        prev_done = 1'b0;

  always #5 clk = ~clk;

  sparse_encoder #(
    .VEC_LEN(VEC_LEN),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .out_val  (out_val),
    .out_index(out_index),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done)
`ifdef NNZ_COUNT_EN
    ,
    .nnz_count(nnz_count)
`endif
  );

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares outputs against the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    exp_pair_t e;
    if (!rst) begin
      prev_last_pop = 1'b0;
      prev_done     = 1'b0;
    end else begin
      check_output("out_valid", int'(out_valid), int'(sb.size() > 0));
      check_output("din_ready", int'(din_ready), int'(!draining && sb.size() < FIFO_DEPTH));
      check_output("done", int'(done), int'(prev_last_pop));
`ifdef NNZ_COUNT_EN
      if (prev_done && nnz_q.size() > 0) check_output("nnz_count", int'(nnz_count), nnz_q.pop_front());
`endif
      prev_done = done;
      if (done) begin
        draining = 1'b0;
        done_count++;
      end
      prev_last_pop = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pair: got val=%0d index=%0d, expected no pair", out_val, out_index);
        end else begin
          e = sb.pop_front();
          check_output("out_val", int'(out_val), e.val);
          check_output("out_index", int'(out_index), e.index);
          check_output("out_last", int'(out_last), int'(e.last));
          prev_last_pop = e.last;
        end
      end
    end
  end

  // Drives one element and, once accepted, records what the encoder must produce for it.
  task automatic apply_stimulus(input logic [7:0] val, input int gap);
    int tries = 0;
    bit acc = 1'b0;
    exp_pair_t e;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    din       = val;
    din_valid = 1'b1;
    while (!acc && tries < TIMEOUT) begin
      @(negedge clk);
      acc = din_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    din_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept in %0d cycles, expected accept", TIMEOUT);
      return;
    end
    accepted++;
    if (val != 0) nnz_cur++;
    if (vec_pos == VEC_LEN - 1) begin
      e = '{val: int'(val), index: vec_pos, last: 1'b1};
      sb.push_back(e);
      nnz_q.push_back(nnz_cur);
      nnz_cur  = 0;
      draining = 1'b1;
    end else if (val != 0) begin
      e = '{val: int'(val), index: vec_pos, last: 1'b0};
      sb.push_back(e);
    end
    vec_pos = (vec_pos + 1) % VEC_LEN;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() > 0 || draining) && t < TIMEOUT) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= TIMEOUT) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pairs pending, expected 0", sb.size());
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_vectors(input int count, input int max_gap);
    for (int v = 0; v < count * VEC_LEN; v++) begin
      logic [7:0] val;
      val = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      apply_stimulus(val, int'($urandom_range(0, max_gap)));
    end
  endtask

  initial begin
    int base;
    logic [7:0] vec_a [8];
    vec_a = '{8'd0, 8'd0, 8'd0, 8'd25, 8'd0, 8'd5, 8'd0, 8'd4};

    #2;
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_val", int'(out_val), 0);
    check_output("reset_out_index", int'(out_index), 0);
    check_output("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed vector 0,0,0,25,0,5,0,4");
    ready_mode = 1;
    base = done_count;
    for (int i = 0; i < VEC_LEN; i++) apply_stimulus(vec_a[i], 0);
    wait_drain();
    check_output("done_pulses_vec_a", done_count - base, 1);

    $display("[TB] all-zero vector");
    base = done_count;
    for (int i = 0; i < VEC_LEN; i++) apply_stimulus(8'd0, 0);
    wait_drain();
    check_output("done_pulses_zero", done_count - base, 1);

    $display("[TB] backpressure with full FIFO");
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    base = accepted;
    fork
      for (int i = 0; i < VEC_LEN; i++) apply_stimulus(8'(i + 1), 0);
      begin
        repeat (12) begin
          @(posedge clk);
          #1;
        end
        check_output("stall_accepts", accepted - base, FIFO_DEPTH);
        check_output("stall_din_ready", int'(din_ready), 0);
        ready_mode = 1;
      end
    join
    wait_drain();

    $display("[TB] back-to-back random vectors");
    ready_mode = 2;
    random_vectors(3, 0);
    wait_drain();

    $display("[TB] reset mid-vector");
    ready_mode = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    apply_stimulus(8'd7, 0);
    apply_stimulus(8'd9, 0);
    apply_stimulus(8'd11, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_output("midreset_out_valid", int'(out_valid), 0);
    check_output("midreset_out_val", int'(out_val), 0);
    check_output("midreset_out_index", int'(out_index), 0);
    check_output("midreset_out_last", int'(out_last), 0);
    check_output("midreset_done", int'(done), 0);
    sb.delete();
    nnz_q.delete();
    vec_pos  = 0;
    nnz_cur  = 0;
    draining = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < VEC_LEN; i++) apply_stimulus(8'(3 * i + 1), 0);
    wait_drain();

    $display("[TB] random vectors with gaps and random backpressure");
    ready_mode = 2;
    random_vectors(6, 2);
    wait_drain();

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/sparse_encoder.md
SPARSE_ENCODER -- requirements
Module: sparse_encoder

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16: dense elements per activation vector (2..256).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output pair buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din  input  8  dense activation element.
REQ-006 SHALL have port din_valid  input  1  din holds an element.
REQ-007 SHALL have port din_ready  output  1  encoder accepts din this cycle.
REQ-008 SHALL have port out_val  output  8  nonzero value; drives PE in.
REQ-009 SHALL have port out_index  output  8  element position in vector; drives PE index_in.
REQ-010 SHALL have port out_last  output  1  pair closes the vector.
REQ-011 SHALL have port out_valid  output  1  pair present.
REQ-012 SHALL have port out_ready  input  1  downstream PE consumes pair.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a vector is fully drained.

Function
REQ-014 SHALL accept an element when din_valid && din_ready; pop a pair when out_valid && out_ready.
REQ-015 SHALL keep element counter idx, 0..VEC_LEN-1, incremented per accepted element, wrapping to 0 after VEC_LEN-1.
REQ-016 SHALL push {din, idx, 0} when din != 0 and idx != VEC_LEN-1; SHALL drop zero elements (counter still advances).
REQ-017 SHALL always push the element at idx == VEC_LEN-1 with last=1, even when din == 0 (zero pair harmless to PE multiply).
REQ-018 SHALL register pushes: element accepted cycle N -> out_valid earliest cycle N+1; no combinational din->out path.
REQ-019 SHALL drive din_ready = 0 when FIFO full, including a cycle with simultaneous pop (no bypass); empty FIFO -> out_valid = 0.
REQ-020 SHALL run FSM IDLE -> RUN on first accepted element; RUN -> DRAIN when last element accepted; DRAIN -> IDLE when FIFO empty, pulsing done in that transition cycle.
REQ-021 SHALL hold din_ready = 0 in DRAIN; out_val/out_index/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 VEC_LEN == 1 out of range; idx width SHALL be 8 bits, upper bits zero.

Reset
REQ-023 SHALL on rst low immediately clear: FSM to IDLE, idx 0, FIFO empty, out_valid 0, out_val 0, out_index 0, out_last 0, done 0; din_ready 1 after release.
REQ-024 SHALL discard in-flight pairs and partial vector on reset mid-operation; next vector starts at idx 0.

Configuration
REQ-025 With NNZ_COUNT_EN defined, SHALL add output nnz_count (8 bits): count of nonzero elements in last completed vector, updated on done, reset 0.
REQ-026 Without NNZ_COUNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package sparse_pkg SHALL hold DATA_W=8, IDX_W=8, FSM state enum, and pair struct {val, index, last}.
REQ-028 FIFO SHALL be sub-module sync_fifo (parameter depth/width; full, empty, push, pop), instantiated once.

Verification
REQ-029 VEC_LEN=8, din 0,0,0,25,0,5,0,4, out_ready=1 -> pairs (25,3,0),(5,5,0),(4,7,1); done one cycle after last pop.
REQ-030 VEC_LEN=8, all zeros -> single pair (0,7,1); done; nnz_count=0 if NNZ_COUNT_EN.
REQ-031 FIFO_DEPTH=4, 8 nonzero elements, out_ready=0 -> din_ready drops after 4 accepts; release -> indices 0..7 in order, no loss.
REQ-032 Two back-to-back vectors -> second starts at index 0 after done; din_ready low during DRAIN.
REQ-033 rst low after 3 accepted elements, pairs pending -> outputs zero, FIFO empty immediately; next vector indices from 0.
